reg_responder: RTL and testbench
================================

REG_RESPONDER -- requirements
Module: reg_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, request address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-003 SHALL have parameter DEPTH, default 12, number of implemented registers; legal range 1..2**ADDR_W.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  responder accepts the request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  register index.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data; zero for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  address >= DEPTH.
REQ-015 SHALL have port txn_count  output  16  completed-transaction count.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-017 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready; IDLE->ACCESS on handshake, latching write, addr and wdata.
REQ-018 SHALL, in ACCESS, perform the register write (only if addr < DEPTH) or capture the read data, compute rsp_err, then move ACCESS->RESP unconditionally.
REQ-019 SHALL assert rsp_valid only in RESP, exactly 2 cycles after the request handshake edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL move RESP->IDLE on rsp_valid & rsp_ready; no new request is accepted in that same cycle (req_ready rises the following cycle).
REQ-022 SHALL, when addr >= DEPTH, drop the write, set rsp_err=1 and return rsp_rdata=0.
REQ-023 SHALL increment txn_count by 1 on each response handshake, including errored ones; it wraps 0xFFFF->0x0000.
REQ-024 SHALL ignore req_* inputs outside IDLE and rsp_ready outside RESP.
REQ-025 SHALL return the most recently written value on a read of a written address, including a read immediately after the write's response.

Reset
REQ-026 SHALL, on rst_n low at any time (including mid-transaction), force state=IDLE, req_ready=0 while rst_n is low and 1 from the first clk edge after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, txn_count=0, and all DEPTH registers=0.
REQ-027 SHALL discard any in-flight transaction on reset; it produces no response and no count.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/ACCESS/RESP) and default ADDR_W/DATA_W constants in package reg_responder_pkg.
REQ-029 SHALL keep the register array in one sub-module, reg_responder_regs (write port, combinational read port, async reset clear).

Verification
REQ-030 Write 0xDEADBEEF to addr 3, then read addr 3 -> rsp_valid 2 cycles after each handshake; read returns 0xDEADBEEF, rsp_err=0, txn_count=2.
REQ-031 Read addr 12 with DEPTH=12 -> rsp_err=1, rsp_rdata=0; prior write of 0x5 to addr 12 leaves every register unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles after read of addr 0 -> rsp_valid, rsp_rdata, rsp_err constant; req_ready=0 throughout; req_valid pulses ignored.
REQ-033 Assert rst_n=0 while in ACCESS for a write to addr 1 -> no response, txn_count=0, subsequent read of addr 1 returns 0.
REQ-034 Back-to-back: req_valid held high, rsp_ready held high for 4 writes -> one transaction per 3 cycles, txn_count=4.
REQ-035 Preload txn_count to 0xFFFF via 65535 transactions, then one more -> txn_count=0x0000.

Source files
------------

// File: rtl/reg_responder_pkg.sv
// Shared constants and FSM state type for the register responder.
package reg_responder_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/reg_responder_regs.sv
// Register array: one write port, combinational read port, async clear.
module reg_responder_regs
  import reg_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < DEPTH_L) rdata = mem[raddr];
  end

endmodule

// File: rtl/reg_responder.sv
// Single-outstanding register responder: request -> access -> response handshake.
module reg_responder
  import reg_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              armed_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data;
  logic              addr_ok;
  logic              req_hs;
  logic              rsp_hs;
  logic              reg_we;

  // armed_q keeps req_ready low during reset and until the first edge after release
  assign req_ready = armed_q && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign req_hs    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign addr_ok   = ({1'b0, addr_q} < DEPTH_L);
  assign reg_we    = (state_q == ACCESS) && wr_q && addr_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (req_hs) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS) begin
        rsp_err   <= !addr_ok;
        rsp_rdata <= (!wr_q && addr_ok) ? rd_data : '0;
      end
      if (rsp_hs) txn_count <= txn_count + 16'd1;
    end
  end

  reg_responder_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (reg_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_reg_responder.sv
// Directed self-checking bench for reg_responder (DEPTH=12, ADDR_W=4, DATA_W=32).
module tb_reg_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] txn_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  reg_responder #(
    .ADDR_W (4),
    .DATA_W (32),
    .DEPTH  (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .txn_count (txn_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One transaction; hold > 0 stalls rsp_ready and probes stability meanwhile.
  task automatic txn(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    check("access_no_rsp", {31'd0, rsp_valid}, 32'd0);
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("rsp_latency", n, 32'd2);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0]; req_write = 1'b1; req_addr = a; req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_err", {31'd0, rsp_err}, {31'd0, er});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          hs_cyc [4];
    int          k, idx, c;
    logic        pending;

    for (int i = 0; i < 16; i++) model[i] = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_count", {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_req_ready_lo", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rel_req_ready_hi", {31'd0, req_ready}, 32'd1);

    // Write then read back
    txn(1'b1, 4'd3, 32'hDEAD_BEEF, 0, rd, er);
    model[3] = 32'hDEAD_BEEF;
    check("wr3_rdata", rd, 32'd0);
    check("wr3_err", {31'd0, er}, 32'd0);
    txn(1'b0, 4'd3, 32'd0, 0, rd, er);
    check("rd3_rdata", rd, 32'hDEAD_BEEF);
    check("rd3_err", {31'd0, er}, 32'd0);
    check("count_2", {16'd0, txn_count}, 32'd2);

    // Out-of-range address
    txn(1'b1, 4'd12, 32'h5, 0, rd, er);
    check("wr12_err", {31'd0, er}, 32'd1);
    check("wr12_rdata", rd, 32'd0);
    txn(1'b0, 4'd12, 32'd0, 0, rd, er);
    check("rd12_err", {31'd0, er}, 32'd1);
    check("rd12_rdata", rd, 32'd0);
    txn(1'b0, 4'd15, 32'd0, 0, rd, er);
    check("rd15_err", {31'd0, er}, 32'd1);
    for (int a = 0; a < 12; a++) begin
      txn(1'b0, 4'(a), 32'd0, 0, rd, er);
      check("scan_rdata", rd, model[a]);
      check("scan_err", {31'd0, er}, 32'd0);
    end
    check("count_17", {16'd0, txn_count}, 32'd17);

    // Response stall with ignored request pulses
    txn(1'b1, 4'd0, 32'h0BAD_F00D, 0, rd, er);
    model[0] = 32'h0BAD_F00D;
    txn(1'b0, 4'd0, 32'd0, 5, rd, er);
    check("stall_rdata", rd, 32'h0BAD_F00D);
    check("stall_err", {31'd0, er}, 32'd0);
    txn(1'b0, 4'd0, 32'd0, 0, rd, er);
    check("stall_no_write", rd, 32'h0BAD_F00D);
    check("count_20", {16'd0, txn_count}, 32'd20);

    // Back-to-back writes to addr 4..7
    @(negedge clk);
    idx = 0; k = 0; pending = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd4; req_wdata = 32'hA0;
    rsp_ready = 1'b1;
    for (c = 0; c < 40; c++) begin
      if (pending) begin
        pending = 1'b0;
        idx++;
        if (idx == 4) req_valid = 1'b0;
        req_addr = 4'(4 + idx); req_wdata = 32'hA0 + 32'(idx);
      end
      if (req_valid && req_ready && k < 4) begin
        hs_cyc[k] = c; k++; pending = 1'b1;
      end
      if (k == 4 && !pending && !req_valid && txn_count == 16'd24) break;
      @(negedge clk);
    end
    rsp_ready = 1'b0; req_write = 1'b0;
    check("b2b_handshakes", k, 32'd4);
    for (int i = 0; i < 3; i++) check("b2b_spacing", hs_cyc[i+1] - hs_cyc[i], 32'd3);
    check("count_24", {16'd0, txn_count}, 32'd24);
    for (int i = 0; i < 4; i++) model[4+i] = 32'hA0 + 32'(i);
    txn(1'b0, 4'd6, 32'd0, 0, rd, er);
    check("b2b_rd6", rd, 32'hA2);

    // Counter wrap (count seeded near terminal value)
    @(negedge clk);
    force dut.txn_count = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count;
    @(negedge clk);
    check("count_ffff", {16'd0, txn_count}, 32'h0000_FFFF);
    txn(1'b0, 4'd13, 32'd0, 0, rd, er);
    check("count_wrap", {16'd0, txn_count}, 32'd0);
    check("wrap_err", {31'd0, er}, 32'd1);

    // Reset during ACCESS of a write to addr 1
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd1; req_wdata = 32'h1234_5678;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_count", {16'd0, txn_count}, 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_count", {16'd0, txn_count}, 32'd0);
    txn(1'b0, 4'd1, 32'd0, 0, rd, er);
    check("post_rst_rd1", rd, 32'd0);
    txn(1'b0, 4'd3, 32'd0, 0, rd, er);
    check("post_rst_rd3", rd, 32'd0);
    check("post_rst_count2", {16'd0, txn_count}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
